result_writeback: RTL

- Drives the 64-bit result buffer's half-select and writes completed 64-bit words to memory.
- Sequences pairs of 32-bit ALU results into the buffer (lower half, then upper half).
- Snapshots the full buffer word, then issues a memory write with a valid/ready handshake at an auto-incrementing address.
- Sits between the ALU/result buffer and the memory write port; the calculator controller starts it via start_i.

---
 rtl/calculator_pkg.sv | 14 +
 rtl/result_writeback.sv | 81 ++++++++
 2 files changed

// File: rtl/calculator_pkg.sv
// calculator_pkg: shared widths and the writeback FSM state encoding
package calculator_pkg;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ADDR_W        = 10;
  typedef enum logic [2:0] {
    WB_IDLE,
    WB_LOW,
    WB_HIGH,
    WB_CAPTURE,
    WB_WRITE,
    WB_DONE
  } wb_state_e;
endpackage

// File: rtl/result_writeback.sv
// result_writeback: pairs ALU halves into the result buffer and writes each 64-bit word to memory; RESULT_WB_STALL_CNT_EN adds a write-stall counter
module result_writeback
  import calculator_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [CNT_W-1:0]         word_count_i,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  output logic                     loc_sel_o,
  input  logic [MEM_WORD_SIZE-1:0] buffer_i,
  output logic                     mem_we_o,
  input  logic                     mem_ready_i,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef RESULT_WB_STALL_CNT_EN
  , output logic [31:0]            stall_cycles_o
`endif
);
  wb_state_e                state_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [MEM_WORD_SIZE-1:0] wdata_q;
  // Job sequencer: fill low then high half, snapshot the word, hold the write until memory accepts
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WB_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        WB_IDLE:
          if (start_i) begin
            if (word_count_i == '0) state_q <= WB_DONE;
            else begin
              addr_q  <= base_addr_i;
              cnt_q   <= word_count_i;
              state_q <= WB_LOW;
            end
          end
        WB_LOW:  if (result_valid_i) state_q <= WB_HIGH;
        WB_HIGH: if (result_valid_i) state_q <= WB_CAPTURE;
        WB_CAPTURE: begin
          wdata_q <= buffer_i;
          state_q <= WB_WRITE;
        end
        WB_WRITE:
          if (mem_ready_i) begin
            addr_q  <= addr_q + ADDR_W'(1);
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= (cnt_q == CNT_W'(1)) ? WB_DONE : WB_LOW;
          end
        WB_DONE: state_q <= WB_IDLE;
        default: state_q <= WB_IDLE;
      endcase
    end
  end
  assign result_ready_o = (state_q == WB_LOW) || (state_q == WB_HIGH);
  assign loc_sel_o      = (state_q == WB_HIGH) || (state_q == WB_CAPTURE) || (state_q == WB_WRITE);
  assign mem_we_o       = state_q == WB_WRITE;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign busy_o         = state_q != WB_IDLE;
  assign done_o         = state_q == WB_DONE;
`ifdef RESULT_WB_STALL_CNT_EN
  logic [31:0] stall_q;
  // Saturating count of WRITE cycles the memory did not accept, restarted by each accepted job
  always_ff @(posedge clk_i) begin
    if (!rst_ni || (state_q == WB_IDLE && start_i)) stall_q <= '0;
    else if (state_q == WB_WRITE && !mem_ready_i && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles_o = stall_q;
`endif
endmodule
